// File: rtl/muldiv_if.sv
// Decode-side request/response bundle for the HI/LO multiply/divide sequencer.
// The master drives requests; the slave (sequencer) returns read data and status.
interface muldiv_if #(parameter int DATA_WIDTH = 32);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic                  rd_req;
  logic                  rd_hi;
  logic                  flush;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic                  stall;
  logic                  done;

  modport master (
    output start, op, rs_data, rt_data, rd_req, rd_hi, flush,
    input  rd_data, busy, stall, done
  );

  modport slave (
    input  start, op, rs_data, rt_data, rd_req, rd_hi, flush,
    output rd_data, busy, stall, done
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
// The multiply waits a fixed latency; the divide is radix-2 restoring plus one sign-fix cycle.
module muldiv_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int MUL_LATENCY = 4
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [5:0] MUL_LAST = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] DIV_LAST = 6'(W - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t         state, state_nxt;
  logic [5:0]     cnt;
  logic [W-1:0]   hi, lo;
  logic           done_q;
  // opa/opb: multiplicand/multiplier during MUL, quotient-shift/divisor during DIV
  logic [W-1:0]   opa, opb, rem;
  logic           mul_signed, neg_q, neg_r, dvz;
  logic           acc_mul, acc_div, wr_hi, wr_lo, mul_fin, div_step, div_fin;
  logic           div_signed, busy;

  logic signed [W:0]     ma, mb;
  logic signed [2*W-1:0] prod;
  logic [W:0]            rem_sh, diff;
  logic                  ge;

  function automatic logic [W-1:0] abs_val(input logic signed [W-1:0] x, input logic en);
    abs_val = (en && x[W-1]) ? -x : x;
  endfunction

  // A zero divisor yields an all-ones quotient; the restoring loop already leaves |A| as remainder.
  function automatic logic [2*W-1:0] div_result(input logic [W-1:0] q, input logic [W-1:0] r,
                                                input logic nq, input logic nr, input logic dz);
    logic [W-1:0] qf, rf;
    rf = nr ? -r : r;
    qf = dz ? '1 : (nq ? -q : q);
    return {rf, qf};
  endfunction

  assign div_signed = (bus.op == 3'd2);
  assign ma     = {mul_signed & opa[W-1], opa};
  assign mb     = {mul_signed & opb[W-1], opb};
  assign prod   = (2*W)'(ma) * (2*W)'(mb);
  assign rem_sh = {rem, opa[W-1]};
  assign diff   = rem_sh - {1'b0, opb};
  assign ge     = ~diff[W];

  always_comb begin
    state_nxt = state;
    acc_mul   = 1'b0;
    acc_div   = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    mul_fin   = 1'b0;
    div_step  = 1'b0;
    div_fin   = 1'b0;
    case (state)
      IDLE: if (bus.start && !bus.flush) begin
        case (bus.op)
          3'd0, 3'd1: begin acc_mul = 1'b1; state_nxt = MUL; end
          3'd2, 3'd3: begin acc_div = 1'b1; state_nxt = DIV; end
          3'd4:       wr_hi = 1'b1;
          3'd5:       wr_lo = 1'b1;
          default:    ;
        endcase
      end
      MUL: begin
        if (bus.flush) state_nxt = IDLE;
        else if (cnt == MUL_LAST) begin
          mul_fin   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DIV: begin
        if (bus.flush) state_nxt = IDLE;
        else begin
          div_step = 1'b1;
          if (cnt == DIV_LAST) state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = IDLE;
        div_fin   = ~bus.flush;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= mul_fin | div_fin;
      if ((state_nxt == MUL || state_nxt == DIV) && state != IDLE) cnt <= cnt + 6'd1;
      else                                                         cnt <= '0;
      if (wr_hi)   hi <= bus.rs_data;
      if (wr_lo)   lo <= bus.rs_data;
      if (mul_fin) {hi, lo} <= prod;
      if (div_fin) {hi, lo} <= div_result(opa, rem, neg_q, neg_r, dvz);
    end
  end

  always_ff @(posedge clk) begin
    if (acc_mul) begin
      opa        <= bus.rs_data;
      opb        <= bus.rt_data;
      mul_signed <= (bus.op == 3'd0);
    end else if (acc_div) begin
      opa   <= abs_val(bus.rs_data, div_signed);
      opb   <= abs_val(bus.rt_data, div_signed);
      rem   <= '0;
      dvz   <= (bus.rt_data == '0);
      neg_r <= div_signed & bus.rs_data[W-1];
      neg_q <= div_signed & (bus.rs_data[W-1] ^ bus.rt_data[W-1]);
    end else if (div_step) begin
      rem <= ge ? diff[W-1:0] : rem_sh[W-1:0];
      opa <= {opa[W-2:0], ge};
    end
  end

  assign busy        = (state != IDLE);
  assign bus.busy    = busy;
  assign bus.stall   = busy & (bus.start | bus.rd_req);
  assign bus.done    = done_q;
  assign bus.rd_data = bus.rd_hi ? hi : lo;
endmodule
